// File: rtl/bp_cce_ucode_loader.sv
// CCE microcode loader: streams instructions into the ucode RAM; with
// BP_CCE_UCODE_VERIFY_EN defined it reads them back and compares checksums.
module bp_cce_ucode_loader #(
   parameter int cce_pc_width_p    = 8,
   parameter int cce_instr_width_p = 48
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         start_i,
   input  logic [cce_pc_width_p:0]      len_i,
   input  logic                         instr_v_i,
   input  logic [cce_instr_width_p-1:0] instr_i,
   output logic                         instr_ready_o,
   output logic                         ucode_v_o,
   output logic                         ucode_w_o,
   output logic [cce_pc_width_p-1:0]    ucode_addr_o,
   output logic [cce_instr_width_p-1:0] ucode_data_o,
   input  logic [cce_instr_width_p-1:0] ucode_data_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         error_o
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      VERIFY,
      DRAIN,
      DONE
   } state_e;

   localparam logic [cce_pc_width_p:0] one_lp = 1;

   state_e                  state_r, state_n;
   logic [cce_pc_width_p:0] cnt_r, cnt_n;
   logic [cce_pc_width_p:0] len_r, len_n;
   logic                    done_r, done_n;
   logic                    start_ok;
   logic                    wr_end;
   logic                    rd_last;
   logic                    accept;

   assign start_ok = start_i
                   & ((state_r == IDLE) | (state_r == DONE));
   assign wr_end   = (cnt_r == len_r);
   assign rd_last  = (cnt_r == (len_r - one_lp));
   assign accept   = instr_v_i & instr_ready_o;

   assign busy_o = (state_r == WRITE)
                 | (state_r == VERIFY)
                 | (state_r == DRAIN);
   assign done_o = done_r;

   // RAM-side outputs are gated by reset so no write leaks out mid-reset
   always_comb begin
      instr_ready_o = 1'b0;
      ucode_v_o     = 1'b0;
      ucode_w_o     = 1'b0;
      ucode_addr_o  = cnt_r[cce_pc_width_p-1:0];
      ucode_data_o  = instr_i;
      if (!reset_i) begin
         case (state_r)
            WRITE: begin
               if (!wr_end) begin
                  instr_ready_o = 1'b1;
                  ucode_v_o     = instr_v_i;
                  ucode_w_o     = instr_v_i;
               end
            end
            VERIFY: begin
               ucode_v_o = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      len_n   = len_r;
      done_n  = done_r;
      case (state_r)
         IDLE, DONE: begin
            if (start_i) begin
               len_n  = len_i;
               cnt_n  = '0;
               done_n = 1'b0;
               state_n = WRITE;
               if (len_i == '0) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end
            end
         end
         WRITE: begin
            if (wr_end) begin
               cnt_n = '0;
`ifdef BP_CCE_UCODE_VERIFY_EN
               state_n = VERIFY;
`else
               state_n = DONE;
               done_n  = 1'b1;
`endif
            end else if (accept) begin
               cnt_n = cnt_r + one_lp;
            end
         end
`ifdef BP_CCE_UCODE_VERIFY_EN
         VERIFY: begin
            cnt_n = cnt_r + one_lp;
            if (rd_last) begin
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            state_n = DONE;
            done_n  = 1'b1;
         end
`endif
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         len_r   <= '0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         len_r   <= len_n;
         done_r  <= done_n;
      end
   end

`ifdef BP_CCE_UCODE_VERIFY_EN
   logic [cce_instr_width_p-1:0] wsum_r, wsum_n;
   logic [cce_instr_width_p-1:0] rsum_r, rsum_n;
   logic                         rd_pend_r;
   logic                         err_r, err_n;

   // The last read returns during DRAIN, so compare against rsum_n
   always_comb begin
      wsum_n = wsum_r;
      rsum_n = rsum_r;
      err_n  = err_r;
      if (start_ok) begin
         wsum_n = '0;
         rsum_n = '0;
         err_n  = 1'b0;
      end else begin
         if (accept) begin
            wsum_n = wsum_r ^ instr_i;
         end
         if (rd_pend_r) begin
            rsum_n = rsum_r ^ ucode_data_i;
         end
         if (state_r == DRAIN) begin
            err_n = (wsum_r != rsum_n);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wsum_r    <= '0;
         rsum_r    <= '0;
         rd_pend_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         wsum_r    <= wsum_n;
         rsum_r    <= rsum_n;
         rd_pend_r <= (state_r == VERIFY);
         err_r     <= err_n;
      end
   end

   assign error_o = err_r;
`else
   logic unused_rdata;
   assign unused_rdata = ^ucode_data_i;
   assign error_o      = 1'b0;
`endif

endmodule
